// File: rtl/mult_pkg.sv
// mult_pkg: shared widths for the unsigned Wallace/CLA multiplier
package mult_pkg;
  localparam int OP_W = 16;
  localparam int PROD_W = 32;
  localparam int CLA_GRP = 4;
endpackage

// File: rtl/cla_adder_32.sv
// cla_adder_32: two-level carry-lookahead adder; a,b -> sum, cout (carry-in fixed at 0)
module cla_adder_32
  import mult_pkg::*;
(
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] sum,
  output logic              cout
);
  localparam int NG = PROD_W / CLA_GRP;
  logic [PROD_W-1:0] g, p, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0] gc;
  logic t;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c = '0;
    t = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp[3'(k)] = &p[k*CLA_GRP +: CLA_GRP];
      for (int i = 0; i < CLA_GRP; i++) begin
        t = g[5'(k*CLA_GRP+i)];
        for (int m = i + 1; m < CLA_GRP; m++) t = t & p[5'(k*CLA_GRP+m)];
        gg[3'(k)] = gg[3'(k)] | t;
      end
    end
    for (int k = 0; k < NG; k++)
      for (int j = 0; j <= k; j++) begin
        t = gg[3'(j)];
        for (int m = j + 1; m <= k; m++) t = t & gp[3'(m)];
        gc[4'(k+1)] = gc[4'(k+1)] | t;
      end
    for (int k = 0; k < NG; k++)
      for (int i = 0; i < CLA_GRP; i++) begin
        t = gc[4'(k)];
        for (int m = 0; m < i; m++) t = t & p[5'(k*CLA_GRP+m)];
        c[5'(k*CLA_GRP+i)] = t;
        for (int j = 0; j < i; j++) begin
          t = g[5'(k*CLA_GRP+j)];
          for (int m = j + 1; m < i; m++) t = t & p[5'(k*CLA_GRP+m)];
          c[5'(k*CLA_GRP+i)] = c[5'(k*CLA_GRP+i)] | t;
        end
      end
  end
  assign sum = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/wallace_unsigned_multiplier_cla_16.sv
// wallace_unsigned_multiplier_cla_16: registered 16x16 unsigned multiply; clk, rst, A, B -> product=A*B one cycle later
module wallace_unsigned_multiplier_cla_16
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] product
);
  logic [PROD_W-1:0] row0, row1, sum;
  logic unused_cout;
  always_comb begin
    logic [OP_W-1:0] cur [PROD_W];
    logic [OP_W-1:0] nxt [PROD_W];
    int n [PROD_W];
    int nn [PROD_W];
    int h;
    logic x, y, z;
    for (int c = 0; c < PROD_W; c++) begin
      cur[5'(c)] = '0;
      nxt[5'(c)] = '0;
      n[5'(c)] = 0;
      nn[5'(c)] = 0;
    end
    h = 0;
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    row0 = '0;
    row1 = '0;
    for (int i = 0; i < OP_W; i++)
      for (int j = 0; j < OP_W; j++) begin
        cur[5'(i+j)][4'(n[5'(i+j)])] = A[4'(j)] & B[4'(i)];
        n[5'(i+j)] = n[5'(i+j)] + 1;
      end
    for (int l = 0; l < 8; l++) begin
      h = 0;
      for (int c = 0; c < PROD_W; c++) h = n[5'(c)] > h ? n[5'(c)] : h;
      if (h > 2) begin
        for (int c = 0; c < PROD_W; c++) begin
          nxt[5'(c)] = '0;
          nn[5'(c)] = 0;
        end
        for (int c = 0; c < PROD_W; c++)
          for (int k = 0; k < OP_W; k += 3) begin
            x = cur[5'(c)][4'(k)];
            y = cur[5'(c)][4'(k+1)];
            z = k + 2 < n[5'(c)] ? cur[5'(c)][4'(k+2)] : 1'b0;
            if (k + 1 < n[5'(c)]) begin
              // two leftover bits use the same cell with z=0, i.e. a half adder
              nxt[5'(c)][4'(nn[5'(c)])] = x ^ y ^ z;
              nn[5'(c)] = nn[5'(c)] + 1;
              // a carry out of the top column weighs 2^32 and cannot affect an exact 32-bit product
              if (c < PROD_W - 1) begin
                nxt[5'(c+1)][4'(nn[5'(c+1)])] = (x & y) | (z & (x ^ y));
                nn[5'(c+1)] = nn[5'(c+1)] + 1;
              end
            end else if (k < n[5'(c)]) begin
              nxt[5'(c)][4'(nn[5'(c)])] = x;
              nn[5'(c)] = nn[5'(c)] + 1;
            end
          end
        cur = nxt;
        n = nn;
      end
    end
    for (int c = 0; c < PROD_W; c++) begin
      row0[5'(c)] = n[5'(c)] > 0 ? cur[5'(c)][0] : 1'b0;
      row1[5'(c)] = n[5'(c)] > 1 ? cur[5'(c)][1] : 1'b0;
    end
  end
  cla_adder_32 u_cla (.a(row0), .b(row1), .sum(sum), .cout(unused_cout));
  always_ff @(posedge clk) product <= rst ? '0 : sum;
endmodule

// File: tb/tb_wallace_unsigned_multiplier_cla_16.sv
// tb_wallace_unsigned_multiplier_cla_16: random and directed checks against a plain-arithmetic product model
module tb_wallace_unsigned_multiplier_cla_16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] product;
  int checks = 0;
  int errors = 0;
  logic [15:0] cv [7] = '{16'h0, 16'h1, 16'h2, 16'h7FFF, 16'h8000, 16'hFFFE, 16'hFFFF};
  wallace_unsigned_multiplier_cla_16 dut (.clk(clk), .rst(rst), .A(a), .B(b), .product(product));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] exp;
    exp = r ? 32'h0 : 32'(x) * 32'(y);
    rst = r;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, product, exp);
  endtask
  initial begin
    step("reset0", 1'b1, 16'hFFFF, 16'hFFFF);
    step("reset1", 1'b1, 16'hFFFF, 16'hFFFF);
    step("release", 1'b0, 16'hFFFF, 16'hFFFF);
    check("max_const", product, 32'hFFFE0001);
    step("mixed", 1'b0, 16'h2771, 16'h0F67);
    check("mixed_const", product, 32'd39812471);
    step("zero", 1'b0, 16'h0000, 16'hFFFF);
    step("ident", 1'b0, 16'hFFFF, 16'h0001);
    step("one", 1'b0, 16'h0001, 16'h0001);
    step("carry_a000", 1'b0, 16'hA000, 16'hFFFF);
    check("carry_const", product, 32'd2684313600);
    step("msb_sq", 1'b0, 16'h8000, 16'h8000);
    check("msb_const", product, 32'h40000000);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) step("corner", 1'b0, cv[i], cv[j]);
    for (int i = 0; i < 1000; i++)
      step(i == 500 ? "rand_rst" : "rand", i == 500, 16'($urandom), 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_unsigned_multiplier_cla_16.md
Name: wallace_unsigned_multiplier_cla_16

Overview:
- 16x16 unsigned multiplier built from an AND-array partial-product generator, a Wallace-tree carry-save reduction and a carry-lookahead (CLA) final adder.
- The result is registered once, so the block is a single-stage pipelined arithmetic unit for datapaths needing a full 32-bit unsigned product.
- One clock; reset is synchronous and active-high.

Parameters:
- None. Operand width is fixed at 16 and product width at 32. These are shared constants, not overridable parameters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  16  unsigned multiplicand
- B  input  16  unsigned multiplier
- product  output  32  registered unsigned product A*B

Behaviour:
- Arithmetic: product = A * B, fully unsigned, exact, 32 bits. No truncation, no saturation, no overflow possible; max is 0xFFFF*0xFFFF = 0xFFFE0001.
- Partial products: pp[i][j] = A[j] & B[i], for i,j in 0..15; 256 bits at weight i+j.
- Reduction: Wallace tree of full adders (3:2) and half adders (2:2), applied per column each level. Stop when every column holds at most 2 bits, which takes about 6 levels for 16 rows.
  - Level structure is free provided the result is exact.
  - No Booth recoding.
- Final adder: the two 32-bit rows are summed by a CLA built from 4-bit lookahead groups.
  - Group generate/propagate feed a second-level lookahead unit.
  - Carry-in is 0.
  - Carry-out beyond bit 31 is provably 0 and is discarded.
- Timing: the combinational path A,B -> tree -> CLA is captured into the product register on every rising clk edge.
  - Latency is 1 cycle: inputs present before edge k appear on product after edge k.
  - Throughput is one result per cycle.
  - No handshake; every cycle is valid.
- Reset:
  - When rst=1 at a rising edge, product <= 32'h0, regardless of A and B.
  - rst has priority over the data capture.
  - On the first edge with rst=0, product takes A*B of the inputs present before that edge.
  - Asserting rst mid-stream discards the pending result.
- Inputs change between edges: only values settled before the capturing edge matter. There is no internal state other than the product register.
- X handling: not required. Inputs are assumed 2-state after reset.

Decomposition:
- Shared package mult_pkg:
  - localparam OP_W=16 and PROD_W=32
  - CLA group size constant CLA_GRP=4
- Sub-module cla_adder_32: 32-bit two-level carry-lookahead adder with inputs a,b[31:0], output sum[31:0], and carry-out cout.
  - It is the natural reusable unit.
- Full-adder and half-adder cells may be inline expressions or generate loops inside the top module; they are not separate modules.
- The Wallace tree and the output register live in the top module.

Test Plan:
- Reset: hold rst=1 with A=16'hFFFF, B=16'hFFFF for 2 edges -> product=0. Release rst -> next edge product=4294836225 (32'hFFFE0001).
- Mixed operands: A=10097 (16'h2771), B=3943 (16'h0F67) -> product=39812471, one cycle after capture.
- Zero/identity:
  - A=0, B=16'hFFFF -> 0
  - A=16'hFFFF, B=1 -> 65535
  - A=1, B=1 -> 1
- Carry-chain stress:
  - A=40960 (16'hA000), B=65535 -> 2684313600
  - A=16'h8000, B=16'h8000 -> 32'h40000000
- Back-to-back pipelining: apply a new (A,B) every cycle for 1000 random cycles.
  - Each product must equal the golden A*B of the previous cycle's inputs.
  - Insert a mid-stream rst pulse -> product=0 on that edge, with correct results resuming the cycle after.
- Exhaustive corner sweep: A and B each drawn from {0,1,2,16'h7FFF,16'h8000,16'hFFFE,16'hFFFF} (all 49 pairs) -> exact unsigned products.
